// File: rtl/err_injector.sv
`default_nettype none
// ============================================================================
//  Module     : err_injector
//  Description: LFSR-driven single-bit error injector. Registers one N-bit
//               word per clock and XORs in an error mask chosen by one of
//               four modes (pass, periodic single-bit, periodic burst,
//               random-rate). Reports the applied mask and a saturating
//               count of corrupted words.
//  Ports      :
//    clk        in   rising-edge clock
//    reset      in   synchronous active-high reset
//    en         in   injection enable (low: clean registered stream)
//    mode       in   0 pass, 1 single-bit, 2 burst, 3 random-rate
//    period     in   interval in cycles (modes 1/2) / rate threshold (mode 3)
//    burst_len  in   words per burst in mode 2 (0 behaves as 1)
//    stream     in   clean word, bit 1 is the MSB
//    out        out  registered stream ^ mask
//    flip_mask  out  mask applied to the word currently on out
//    busy       out  high while the FSM is in BURST
//    inj_count  out  saturating count of words with a non-zero mask
//  Revision   : 1.0  initial release
// ============================================================================
module err_injector #(
    parameter int          N    = 5,        // word width, 1..255
    parameter logic [15:0] SEED = 16'hACE1  // non-zero LFSR reset value
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [7:0]  period,
    input  logic [3:0]  burst_len,
    input  logic [1:N]  stream,
    output logic [1:N]  out,
    output logic [1:N]  flip_mask,
    output logic        busy,
    output logic [15:0] inj_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_BURST = 2'd2
    } state_t;

    localparam logic [1:0] C_MODE_PASS   = 2'd0;
    localparam logic [1:0] C_MODE_SINGLE = 2'd1;
    localparam logic [1:0] C_MODE_BURST  = 2'd2;
    localparam logic [1:0] C_MODE_RATE   = 2'd3;
    localparam logic [7:0] C_N           = 8'(N);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [7:0]  burst_pos_q, burst_pos_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  period_q, period_d;
    logic [1:N]  out_q, out_d;
    logic [1:N]  flip_mask_q, flip_mask_d;
    logic        busy_q, busy_d;
    logic [15:0] inj_count_q, inj_count_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        lfsr_fb;
    logic [7:0]  pos;
    logic [1:N]  pos_mask;
    logic [1:N]  burst_mask;
    logic [1:N]  mask;
    logic        cfg_change;
    logic        count_ok;
    logic        fire;
    logic [3:0]  bcnt_load;

    // One-hot decode of a 1-based bit position onto the [1:N] word.
    function automatic logic [1:N] bit_mask(input logic [7:0] p);
        logic [1:N] m;
        m = '0;
        for (int i = 1; i <= N; i++) begin
            m[i] = (p == 8'(i));
        end
        return m;
    endfunction

    always_comb begin
        // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10; shift left.
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = en ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;

        // Position is taken from the pre-advance LFSR value.
        pos        = (lfsr_q[7:0] % C_N) + 8'd1;
        pos_mask   = bit_mask(pos);
        burst_mask = bit_mask(burst_pos_q);

        // mode_q/period_q hold last cycle's configuration. The mask is
        // formed from them, so in the cycle a change is sampled the old
        // behaviour still applies; the change itself restarts the FSM.
        mode_d     = mode;
        period_d   = period;
        cfg_change = (mode != mode_q) || (period != period_q);
        count_ok   = ((mode == C_MODE_SINGLE) || (mode == C_MODE_BURST)) &&
                     (period != 8'd0);

        // COUNT is only ever entered with period_q != 0.
        fire      = (state_q == S_COUNT) && (cnt_q == period_q - 8'd1);
        bcnt_load = (burst_len == 4'd0) ? 4'd0 : burst_len - 4'd1;

        // ---------------- mask selection ----------------
        mask = '0;
        if (en) begin
            unique case (state_q)
                S_BURST: mask = burst_mask;
                S_COUNT: if (fire) mask = pos_mask;
                default: begin
                    if ((mode_q == C_MODE_RATE) && (lfsr_q[15:8] < period_q)) begin
                        mask = pos_mask;
                    end
                end
            endcase
        end

        // ---------------- next state ----------------
        state_d     = state_q;
        cnt_d       = cnt_q;
        bcnt_d      = bcnt_q;
        burst_pos_d = burst_pos_q;

        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            bcnt_d  = 4'd0;
        end else if (cfg_change) begin
            // Abort any burst and restart the interval from zero.
            state_d = count_ok ? S_COUNT : S_IDLE;
            cnt_d   = 8'd0;
            bcnt_d  = 4'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = 8'd0;
                    if (count_ok) state_d = S_COUNT;
                end
                S_COUNT: begin
                    if (!count_ok) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end else if (fire) begin
                        cnt_d = 8'd0;
                        if (mode_q == C_MODE_BURST) begin
                            burst_pos_d = pos;
                            bcnt_d      = bcnt_load;
                            if (bcnt_load != 4'd0) state_d = S_BURST;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_BURST: begin
                    // bcnt counts the burst words still to be emitted,
                    // including the current one; cnt is frozen meanwhile.
                    bcnt_d = bcnt_q - 4'd1;
                    if (bcnt_q <= 4'd1) begin
                        bcnt_d  = 4'd0;
                        state_d = S_COUNT;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                    bcnt_d  = 4'd0;
                end
            endcase
        end

        // ---------------- registered outputs ----------------
        out_d       = stream ^ mask;
        flip_mask_d = mask;
        busy_d      = (state_d == S_BURST);
        inj_count_d = inj_count_q;
        if ((mask != '0) && (inj_count_q != 16'hFFFF)) begin
            inj_count_d = inj_count_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            bcnt_q      <= 4'd0;
            burst_pos_q <= 8'd0;
            lfsr_q      <= SEED;
            mode_q      <= C_MODE_PASS;
            period_q    <= 8'd0;
            out_q       <= '0;
            flip_mask_q <= '0;
            busy_q      <= 1'b0;
            inj_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcnt_q      <= bcnt_d;
            burst_pos_q <= burst_pos_d;
            lfsr_q      <= lfsr_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            out_q       <= out_d;
            flip_mask_q <= flip_mask_d;
            busy_q      <= busy_d;
            inj_count_q <= inj_count_d;
        end
    end

    assign out       = out_q;
    assign flip_mask = flip_mask_q;
    assign busy      = busy_q;
    assign inj_count = inj_count_q;

endmodule
`default_nettype wire
